// File: rtl/fp_divide.sv
// ---------------------------------------------------------------------------
// fp_divide
//
// Purpose:
//   Sequential IEEE-754 single-precision divider, Out = In_A / In_B.
//   It uses the same number model as the FP32 multiplier:
//     - normal numbers only (no denormals, no NaN),
//     - truncation instead of rounding.
//   The mantissa quotient comes from a restoring divider that resolves
//   BITS_PER_CYCLE quotient bits per clock. Each operation runs through
//   the states IDLE -> DIVIDE -> NORM -> DONE, and its latency is fixed.
//
// Parameters:
//   BITS_PER_CYCLE  quotient bits per DIVIDE cycle (1 or 5; must divide 25)
//   EXP_BIAS        exponent bias (127)
//
// Ports:
//   clk        in   1   clock; all state updates on the rising edge
//   rst        in   1   synchronous active-high reset
//   valid_in   in   1   operands valid; accepted only while busy is low
//   In_A       in   32  dividend, FP32
//   In_B       in   32  divisor, FP32
//   Out        out  32  quotient, registered; held until the next result
//   valid_out  out  1   one-cycle pulse that marks a new Out
//   busy       out  1   high while an operation is in flight
//
// Configuration macro:
//   FP_DIV_RANGE_CHECK_EN
//     defined   -> an exponent overflow saturates to signed infinity,
//                  and an exponent underflow flushes to signed zero
//     undefined -> the exponent wraps to its low 8 bits
// ---------------------------------------------------------------------------
module fp_divide #(
  parameter int BITS_PER_CYCLE = 1,
  parameter int EXP_BIAS       = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] In_A,
  input  logic [31:0] In_B,
  output logic [31:0] Out,
  output logic        valid_out,
  output logic        busy
);

  localparam int NSTEPS = 25 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_ITER = 5'(NSTEPS - 1);
  localparam logic signed [9:0] BIAS10 = 10'(EXP_BIAS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_NORM   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        iter_q, iter_d;
  logic [23:0]       frac_b_q, frac_b_d;
  logic [24:0]       rem_q, rem_d;
  logic [24:0]       quo_q, quo_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              a_zero_q, a_zero_d;
  logic              b_zero_q, b_zero_d;
  logic [31:0]       out_q, out_d;

  logic              capture;
  logic [49:0]       step_res;

  // One DIVIDE cycle: BITS_PER_CYCLE restoring steps.
  // Invariant: the partial remainder stays below 2*divisor. So each step
  // yields exactly one quotient bit, and the doubled remainder fits in
  // 25 bits.
  function automatic logic [49:0] div_steps(input logic [24:0] rem,
                                            input logic [24:0] quo,
                                            input logic [23:0] divisor);
    logic [24:0] r;
    logic [24:0] q;
    r = rem;
    q = quo;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r >= {1'b0, divisor}) begin
        r = r - {1'b0, divisor};
        q = {q[23:0], 1'b1};
      end else begin
        q = {q[23:0], 1'b0};
      end
      r = {r[23:0], 1'b0};
    end
    return {r, q};
  endfunction

  // Normalise the quotient, then apply special cases and the exponent
  // range policy.
  // Q lies in [2^23, 2^25), so at most one position of left-shift
  // (with an exponent decrement) is needed.
  function automatic logic [31:0] pack_result(input logic              sign,
                                              input logic signed [9:0] exp_t,
                                              input logic [24:0]       q,
                                              input logic              a_zero,
                                              input logic              b_zero);
    logic signed [9:0] e;
    logic [22:0]       f;
    if (q[24]) begin
      e = exp_t;
      f = q[23:1];
    end else begin
      e = exp_t - 10'sd1;
      f = q[22:0];
    end
    if (a_zero) return 32'h0000_0000;
    if (b_zero) return {sign, 8'hFF, 23'h0};
`ifdef FP_DIV_RANGE_CHECK_EN
    if (e >= 10'sd255) return {sign, 8'hFF, 23'h0};
    if (e <= 10'sd0)   return {sign, 31'h0};
`endif
    return {sign, e[7:0], f};
  endfunction

  // A new operation can start from IDLE, or from DONE (back-to-back).
  assign capture  = valid_in && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign step_res = div_steps(rem_q, quo_q, frac_b_q);

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    frac_b_d = frac_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;
    out_d    = out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (capture) begin
          state_d  = S_DIVIDE;
          iter_d   = 5'd0;
          rem_d    = {2'b01, In_A[22:0]};
          quo_d    = 25'd0;
          frac_b_d = {1'b1, In_B[22:0]};
          exp_d    = $signed({2'b00, In_A[30:23]}) - $signed({2'b00, In_B[30:23]}) + BIAS10;
          sign_d   = In_A[31] ^ In_B[31];
          a_zero_d = (In_A[30:0] == 31'd0);
          b_zero_d = (In_B[30:0] == 31'd0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIVIDE: begin
        rem_d  = step_res[49:25];
        quo_d  = step_res[24:0];
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_ITER) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        out_d   = pack_result(sign_q, exp_q, quo_q, a_zero_q, b_zero_q);
        iter_d  = 5'd0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      iter_q   <= 5'd0;
      frac_b_q <= 24'd0;
      rem_q    <= 25'd0;
      quo_q    <= 25'd0;
      exp_q    <= 10'sd0;
      sign_q   <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      out_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      frac_b_q <= frac_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
      out_q    <= out_d;
    end
  end

  assign Out       = out_q;
  assign valid_out = (state_q == S_DONE);
  assign busy      = (state_q == S_DIVIDE) || (state_q == S_NORM);

endmodule
